coreboard1588_rtc_trigger: RTL and testbench
============================================

COREBOARD1588_RTC_TRIGGER -- requirements
Module: coreboard1588_rtc_trigger

Interface
REQ-001 Parameter C_CLOCK_FREQUENCY, default 125000000, clk frequency in Hz; C_NS_STEP = 10**9 / C_CLOCK_FREQUENCY (8 at default).
REQ-002 clk  input  1  sole clock; all logic SHALL be synchronous to its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 rtc_second  input  32  live RTC seconds, same clk domain.
REQ-005 rtc_nanosecond  input  32  live RTC nanoseconds, same clk domain.
REQ-006 ctrl_start_second  input  32  target seconds of first pulse.
REQ-007 ctrl_start_nanosecond  input  32  target nanoseconds of first pulse, 0..999_999_999.
REQ-008 ctrl_period_ns  input  32  repeat period, 0 = one-shot, else 1..999_999_999.
REQ-009 ctrl_width_ns  input  32  pulse width in ns.
REQ-010 ctrl_arm  input  1  one-cycle strobe; samples all ctrl_* fields.
REQ-011 ctrl_disarm  input  1  one-cycle strobe; cancels activity.
REQ-012 trig_out  output  1  registered trigger pulse to pin.
REQ-013 stat_armed  output  1  high in ARMED or PULSE state.
REQ-014 stat_late  output  1  sticky: armed target already passed at arm.
REQ-015 stat_error  output  1  sticky: last arm rejected.
REQ-016 stat_count  output  16  pulses issued since last arm, wraps at 65535->0.

Function
REQ-017 States: IDLE, ARMED, PULSE; exactly one active.
REQ-018 ctrl_arm SHALL latch target {second, ns}, period, width into internal registers; later ctrl_* changes SHALL NOT affect the armed job.
REQ-019 Arm with ctrl_period_ns != 0 and ctrl_period_ns <= ctrl_width_ns SHALL be rejected: stat_error=1, state IDLE, trig_out=0.
REQ-020 Valid arm from any state SHALL: clear stat_error, stat_late, stat_count; abort any pulse (trig_out=0 next cycle); enter ARMED.
REQ-021 Fire condition: {rtc_second, rtc_nanosecond} >= {target_second, target_ns}, unsigned 64-bit compare.
REQ-022 ARMED and fire condition true in cycle N: trig_out=1 from cycle N+1, state PULSE, stat_count+1.
REQ-023 Pulse length SHALL be max(1, ceil(width_ns / C_NS_STEP)) cycles, counted in clk cycles, independent of later RTC jumps.
REQ-024 At fire, if period != 0, target SHALL advance by period: ns += period; if ns >= 10**9 then ns -= 10**9 and second += 1 (second wraps modulo 2**32).
REQ-025 Pulse end: period == 0 -> IDLE; else -> ARMED with advanced target.
REQ-026 If advanced target is already passed on re-entry to ARMED (RTC stepped forward), fire per REQ-022 immediately; no pulses are replayed.
REQ-027 RTC stepped backward: SHALL simply wait until fire condition holds.
REQ-028 stat_late SHALL set if fire condition is true in the first ARMED cycle after arm.
REQ-029 ctrl_disarm SHALL force IDLE and trig_out=0 next cycle; stat_count, stat_late retained.
REQ-030 ctrl_arm and ctrl_disarm in same cycle: disarm wins, arm ignored.

Reset
REQ-031 rst_n=0 at a clk edge: state IDLE, trig_out=0, stat_armed=0, stat_late=0, stat_error=0, stat_count=0, internal target/period/width cleared; applies mid-pulse too.
REQ-032 First arm SHALL be honoured in the first cycle with rst_n=1.

Structure
REQ-033 Package coreboard1588_pkg SHALL hold C_NS_PER_SECOND (10**9) and the state enum typedef.
REQ-034 Time advance (REQ-024) SHALL be a sub-module coreboard1588_time_add: combinational {s,ns}+ns with carry.

Verification (125 MHz, RTC advancing 8 ns/cycle)
REQ-035 RTC from (10,0); arm target (10,500), width 100, period 0 -> trig_out rises cycle after rtc_ns=504, high 13 cycles, stat_count=1, then IDLE.
REQ-036 Arm (5,999_999_000), period 500_000_000, width 16 -> 2-cycle pulses after RTC reaches (5,999_999_000) and (6,499_999_000); stat_count=2.
REQ-037 RTC at (20,0); arm target (19,0) -> trig_out=1 next-but-one cycle, stat_late=1.
REQ-038 Disarm on 3rd pulse cycle -> trig_out=0 next cycle, stat_armed=0, no later pulses; arm+disarm same cycle -> stays IDLE.
REQ-039 Arm period 16, width 16 -> stat_error=1, no pulse ever.
REQ-040 rst_n=0 mid-pulse -> all outputs 0 next cycle; re-arm after release works per REQ-035.

Source files
------------

// File: rtl/coreboard1588_pkg.sv
// Shared constants, state encoding and pulse-length helper for the RTC trigger.
package coreboard1588_pkg;

  localparam int unsigned C_NS_PER_SECOND = 32'd1_000_000_000;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StPulse
  } state_e;

  // max(1, ceil(width_ns / ns_step)); 33 bits so the rounding add cannot overflow
  function automatic logic [32:0] pulse_cycles(input logic [31:0] width_ns,
                                               input int unsigned ns_step);
    logic [32:0] cycles;
    cycles = ({1'b0, width_ns} + 33'(ns_step) - 33'd1) / 33'(ns_step);
    if (cycles == '0) begin
      cycles = 33'd1;
    end
    return cycles;
  endfunction

endpackage

// File: rtl/coreboard1588_time_add.sv
// Combinational {second, nanosecond} + nanoseconds with a single carry into seconds.
module coreboard1588_time_add
  import coreboard1588_pkg::*;
(
  input  logic [31:0] second,
  input  logic [31:0] nanosecond,
  input  logic [31:0] add_ns,
  output logic [31:0] sum_second,
  output logic [31:0] sum_nanosecond
);

  logic [32:0] ns_sum;

  // Both operands are below one second, so one subtraction normalises the sum
  always_comb begin
    ns_sum         = {1'b0, nanosecond} + {1'b0, add_ns};
    sum_second     = second;
    sum_nanosecond = ns_sum[31:0];
    if (ns_sum >= 33'(C_NS_PER_SECOND)) begin
      sum_nanosecond = 32'(ns_sum - 33'(C_NS_PER_SECOND));
      sum_second     = second + 32'd1;
    end
  end

endmodule

// File: rtl/coreboard1588_rtc_trigger.sv
// Fires a pulse on trig_out when the live RTC reaches an armed target time,
// optionally repeating with a fixed period.
module coreboard1588_rtc_trigger
  import coreboard1588_pkg::*;
#(
  parameter int unsigned C_CLOCK_FREQUENCY = 125000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] rtc_second,
  input  logic [31:0] rtc_nanosecond,
  input  logic [31:0] ctrl_start_second,
  input  logic [31:0] ctrl_start_nanosecond,
  input  logic [31:0] ctrl_period_ns,
  input  logic [31:0] ctrl_width_ns,
  input  logic        ctrl_arm,
  input  logic        ctrl_disarm,
  output logic        trig_out,
  output logic        stat_armed,
  output logic        stat_late,
  output logic        stat_error,
  output logic [15:0] stat_count
);

  localparam int unsigned C_NS_STEP = C_NS_PER_SECOND / C_CLOCK_FREQUENCY;

  state_e      state_q, state_d;
  logic [31:0] tgt_sec_q, tgt_sec_d;
  logic [31:0] tgt_ns_q, tgt_ns_d;
  logic [31:0] period_q, period_d;
  logic [32:0] width_cyc_q, width_cyc_d;
  logic [32:0] remain_q, remain_d;
  logic        trig_q, trig_d;
  logic        late_q, late_d;
  logic        error_q, error_d;
  logic [15:0] count_q, count_d;
  logic        first_q, first_d;

  logic [31:0] adv_sec, adv_ns;
  logic        fire;
  logic        arm_bad;

  coreboard1588_time_add u_time_add (
    .second         (tgt_sec_q),
    .nanosecond     (tgt_ns_q),
    .add_ns         (period_q),
    .sum_second     (adv_sec),
    .sum_nanosecond (adv_ns)
  );

  assign fire    = {rtc_second, rtc_nanosecond} >= {tgt_sec_q, tgt_ns_q};
  assign arm_bad = (ctrl_period_ns != 32'd0) && (ctrl_period_ns <= ctrl_width_ns);

  always_comb begin
    state_d     = state_q;
    tgt_sec_d   = tgt_sec_q;
    tgt_ns_d    = tgt_ns_q;
    period_d    = period_q;
    width_cyc_d = width_cyc_q;
    remain_d    = remain_q;
    trig_d      = trig_q;
    late_d      = late_q;
    error_d     = error_q;
    count_d     = count_q;
    first_d     = 1'b0;

    if (ctrl_disarm) begin
      state_d = StIdle;
      trig_d  = 1'b0;
    end else if (ctrl_arm) begin
      trig_d = 1'b0;
      if (arm_bad) begin
        error_d = 1'b1;
        state_d = StIdle;
      end else begin
        tgt_sec_d   = ctrl_start_second;
        tgt_ns_d    = ctrl_start_nanosecond;
        period_d    = ctrl_period_ns;
        width_cyc_d = pulse_cycles(ctrl_width_ns, C_NS_STEP);
        remain_d    = '0;
        error_d     = 1'b0;
        late_d      = 1'b0;
        count_d     = '0;
        first_d     = 1'b1;
        state_d     = StArmed;
      end
    end else begin
      unique case (state_q)
        StArmed: begin
          if (fire) begin
            state_d  = StPulse;
            trig_d   = 1'b1;
            count_d  = count_q + 16'd1;
            remain_d = width_cyc_q - 33'd1;
            if (first_q) begin
              late_d = 1'b1;
            end
            if (period_q != 32'd0) begin
              tgt_sec_d = adv_sec;
              tgt_ns_d  = adv_ns;
            end
          end
        end
        StPulse: begin
          if (remain_q == '0) begin
            trig_d  = 1'b0;
            state_d = (period_q == 32'd0) ? StIdle : StArmed;
          end else begin
            remain_d = remain_q - 33'd1;
          end
        end
        default: begin
          trig_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tgt_sec_q   <= '0;
      tgt_ns_q    <= '0;
      period_q    <= '0;
      width_cyc_q <= '0;
      remain_q    <= '0;
      trig_q      <= 1'b0;
      late_q      <= 1'b0;
      error_q     <= 1'b0;
      count_q     <= '0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_sec_q   <= tgt_sec_d;
      tgt_ns_q    <= tgt_ns_d;
      period_q    <= period_d;
      width_cyc_q <= width_cyc_d;
      remain_q    <= remain_d;
      trig_q      <= trig_d;
      late_q      <= late_d;
      error_q     <= error_d;
      count_q     <= count_d;
      first_q     <= first_d;
    end
  end

  assign trig_out   = trig_q;
  assign stat_armed = (state_q != StIdle);
  assign stat_late  = late_q;
  assign stat_error = error_q;
  assign stat_count = count_q;

endmodule

// File: tb/tb_coreboard1588_rtc_trigger.sv
// Directed bench for the RTC trigger: vector table plus multi-cycle sequences.
module tb_coreboard1588_rtc_trigger;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rtc_second, rtc_nanosecond;
  logic [31:0] ctrl_start_second, ctrl_start_nanosecond, ctrl_period_ns, ctrl_width_ns;
  logic        ctrl_arm, ctrl_disarm;
  logic        trig_out, stat_armed, stat_late, stat_error;
  logic [15:0] stat_count;
  logic        rtc_run;

  int n_cmp  = 0;
  int n_fail = 0;

  always #4 clk = ~clk;

  coreboard1588_rtc_trigger #(.C_CLOCK_FREQUENCY(125000000)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .rtc_second            (rtc_second),
    .rtc_nanosecond        (rtc_nanosecond),
    .ctrl_start_second     (ctrl_start_second),
    .ctrl_start_nanosecond (ctrl_start_nanosecond),
    .ctrl_period_ns        (ctrl_period_ns),
    .ctrl_width_ns         (ctrl_width_ns),
    .ctrl_arm              (ctrl_arm),
    .ctrl_disarm           (ctrl_disarm),
    .trig_out              (trig_out),
    .stat_armed            (stat_armed),
    .stat_late             (stat_late),
    .stat_error            (stat_error),
    .stat_count            (stat_count)
  );

  typedef struct {
    string       name;
    logic [31:0] rtc_s, rtc_ns, tgt_s, tgt_ns, period, width;
    bit          err, late, armed_after;
    int          delay, len;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: outputs sampled 1 time unit after the edge, then RTC advances 8 ns
  task automatic tick();
    @(posedge clk);
    #1;
    if (rtc_run) begin
      if (rtc_nanosecond >= 32'd999_999_992) begin
        rtc_nanosecond = rtc_nanosecond + 32'd8 - 32'd1_000_000_000;
        rtc_second     = rtc_second + 32'd1;
      end else begin
        rtc_nanosecond = rtc_nanosecond + 32'd8;
      end
    end
  endtask

  task automatic set_rtc(input logic [31:0] s, input logic [31:0] ns);
    rtc_second     = s;
    rtc_nanosecond = ns;
  endtask

  task automatic arm(input logic [31:0] s, input logic [31:0] ns,
                     input logic [31:0] p, input logic [31:0] w);
    ctrl_start_second     = s;
    ctrl_start_nanosecond = ns;
    ctrl_period_ns        = p;
    ctrl_width_ns         = w;
    ctrl_arm              = 1'b1;
    tick();
    ctrl_arm = 1'b0;
  endtask

  task automatic disarm();
    ctrl_disarm = 1'b1;
    tick();
    ctrl_disarm = 1'b0;
  endtask

  task automatic wait_rise(input int max, output int d);
    d = -1;
    for (int k = 1; k <= max && d < 0; k++) begin
      tick();
      if (trig_out) d = k;
    end
  endtask

  task automatic measure_len(output int len);
    len = 0;
    while (trig_out && len < 200) begin
      len++;
      tick();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_trig"}, trig_out, 0);
    chk({tag, "_armed"}, stat_armed, 0);
    chk({tag, "_late"}, stat_late, 0);
    chk({tag, "_error"}, stat_error, 0);
    chk({tag, "_count"}, stat_count, 0);
  endtask

  initial begin
    int d, len;

    vecs[0] = '{"basic",    32'd10, 32'd0, 32'd10, 32'd500, 32'd0, 32'd100, 0, 0, 0, 63, 13};
    vecs[1] = '{"late",     32'd20, 32'd0, 32'd19, 32'd0, 32'd0, 32'd8, 0, 1, 0, 1, 1};
    vecs[2] = '{"width0",   32'd1, 32'd0, 32'd1, 32'd16, 32'd0, 32'd0, 0, 0, 0, 2, 1};
    vecs[3] = '{"p_eq_w",   32'd1, 32'd0, 32'd1, 32'd40, 32'd16, 32'd16, 1, 0, 0, -1, 0};
    vecs[4] = '{"width9",   32'd1, 32'd0, 32'd1, 32'd9, 32'd0, 32'd9, 0, 0, 0, 2, 2};
    vecs[5] = '{"sec_wrap", 32'd2, 32'd999_999_992, 32'd3, 32'd0, 32'd0, 32'd24, 0, 1, 0, 1, 3};
    vecs[6] = '{"p17w16",   32'd1, 32'd0, 32'd1, 32'd40, 32'd17, 32'd16, 0, 0, 1, 5, 2};
    vecs[7] = '{"p_lt_w",   32'd1, 32'd0, 32'd1, 32'd40, 32'd5, 32'd100, 1, 0, 0, -1, 0};
    vecs[8] = '{"unsigned", 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd100, 32'd0, 32'd1, 0, 1, 0, 1, 1};

    rst_n = 1'b0;
    rtc_run = 1'b1;
    set_rtc(32'd0, 32'd0);
    ctrl_start_second = '0;
    ctrl_start_nanosecond = '0;
    ctrl_period_ns = '0;
    ctrl_width_ns = '0;
    ctrl_arm = 1'b0;
    ctrl_disarm = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      disarm();
      set_rtc(vecs[i].rtc_s, vecs[i].rtc_ns);
      arm(vecs[i].tgt_s, vecs[i].tgt_ns, vecs[i].period, vecs[i].width);
      chk({vecs[i].name, "_error"}, stat_error, vecs[i].err);
      chk({vecs[i].name, "_armed"}, stat_armed, !vecs[i].err);
      wait_rise(vecs[i].err ? 100 : 200, d);
      chk({vecs[i].name, "_delay"}, d, vecs[i].delay);
      if (!vecs[i].err) begin
        chk({vecs[i].name, "_late"}, stat_late, vecs[i].late);
        chk({vecs[i].name, "_count"}, stat_count, 1);
        measure_len(len);
        chk({vecs[i].name, "_len"}, len, vecs[i].len);
        chk({vecs[i].name, "_armed_after"}, stat_armed, vecs[i].armed_after);
      end
    end

    // Periodic job crossing a second boundary; RTC stepped forward between pulses
    disarm();
    set_rtc(32'd5, 32'd999_998_000);
    arm(32'd5, 32'd999_999_000, 32'd500_000_000, 32'd16);
    wait_rise(200, d);
    chk("per_delay1", d, 125);
    measure_len(len);
    chk("per_len1", len, 2);
    chk("per_count1", stat_count, 1);
    chk("per_armed", stat_armed, 1);
    set_rtc(32'd6, 32'd499_998_000);
    wait_rise(200, d);
    chk("per_delay2", d, 126);
    measure_len(len);
    chk("per_len2", len, 2);
    chk("per_count2", stat_count, 2);

    // Disarm on third pulse cycle, then arm+disarm together
    disarm();
    set_rtc(32'd1, 32'd0);
    arm(32'd1, 32'd16, 32'd1000, 32'd40);
    wait_rise(200, d);
    chk("dis_delay", d, 2);
    tick();
    tick();
    chk("dis_trig3", trig_out, 1);
    disarm();
    chk("dis_trig", trig_out, 0);
    chk("dis_armed", stat_armed, 0);
    chk("dis_count", stat_count, 1);
    wait_rise(300, d);
    chk("dis_no_pulse", d, -1);
    ctrl_start_second = 32'd0;
    ctrl_start_nanosecond = 32'd0;
    ctrl_period_ns = 32'd0;
    ctrl_width_ns = 32'd8;
    ctrl_arm = 1'b1;
    ctrl_disarm = 1'b1;
    tick();
    ctrl_arm = 1'b0;
    ctrl_disarm = 1'b0;
    chk("both_armed", stat_armed, 0);
    wait_rise(20, d);
    chk("both_no_pulse", d, -1);
    chk("both_count", stat_count, 1);

    // Reset mid-pulse, then arm in the first released cycle
    set_rtc(32'd1, 32'd0);
    arm(32'd0, 32'd5, 32'd0, 32'd100);
    wait_rise(20, d);
    chk("rst_pre_delay", d, 1);
    chk("rst_pre_late", stat_late, 1);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk_all_zero("rst_mid");
    set_rtc(32'd10, 32'd0);
    ctrl_start_second = 32'd10;
    ctrl_start_nanosecond = 32'd500;
    ctrl_period_ns = 32'd0;
    ctrl_width_ns = 32'd100;
    rst_n = 1'b1;
    ctrl_arm = 1'b1;
    tick();
    ctrl_arm = 1'b0;
    ctrl_start_second = 32'd999;
    ctrl_width_ns = 32'd8;
    chk("rearm_armed", stat_armed, 1);
    wait_rise(200, d);
    chk("rearm_delay", d, 63);
    chk("rearm_late", stat_late, 0);
    measure_len(len);
    chk("rearm_len", len, 13);
    chk("rearm_count", stat_count, 1);
    chk("rearm_idle", stat_armed, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
